aib_axi_lite_follower: RTL

Follower-side AIB-to-AXI-Lite bridge. It decodes AW/W/AR request words arriving from the AIB PHY receive path and buffers them in per-channel FIFOs. It replays them as a single AXI-Lite master onto the user slave, and encodes B/R responses plus credit returns onto the PHY transmit path. It is the far-end counterpart of the leader bridge, which issues requests against `init_ar_credit`, `init_aw_credit` and `init_w_credit`, all set equal to `FIFO_DEPTH`.

---
 rtl/aib_axi_lite_follower_if.sv | 41 ++++
 rtl/aib_axi_lite_follower.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/aib_axi_lite_follower_if.sv
// rtl/aib_axi_lite_follower_if.sv - AXI-Lite user-side bus between the follower bridge and the user slave
interface aib_axi_lite_follower_if #(
    parameter int ADDRWIDTH = 32,
    parameter int DATAWIDTH = 32
);
    logic [ADDRWIDTH-1:0] user_awaddr;
    logic [2:0]           user_awprot;
    logic                 user_awvalid;
    logic                 user_awready;
    logic [DATAWIDTH-1:0] user_wdata;
    logic [3:0]           user_wstrb;
    logic                 user_wvalid;
    logic                 user_wready;
    logic [1:0]           user_bresp;
    logic                 user_bvalid;
    logic                 user_bready;
    logic [ADDRWIDTH-1:0] user_araddr;
    logic [2:0]           user_arprot;
    logic                 user_arvalid;
    logic                 user_arready;
    logic [DATAWIDTH-1:0] user_rdata;
    logic [1:0]           user_rresp;
    logic                 user_rvalid;
    logic                 user_rready;

    modport master (
        output user_awaddr, user_awprot, user_awvalid, input user_awready,
        output user_wdata, user_wstrb, user_wvalid, input user_wready,
        input user_bresp, user_bvalid, output user_bready,
        output user_araddr, user_arprot, user_arvalid, input user_arready,
        input user_rdata, user_rresp, user_rvalid, output user_rready
    );

    modport slave (
        input user_awaddr, user_awprot, user_awvalid, output user_awready,
        input user_wdata, user_wstrb, user_wvalid, output user_wready,
        output user_bresp, user_bvalid, input user_bready,
        input user_araddr, user_arprot, user_arvalid, output user_arready,
        output user_rdata, user_rresp, user_rvalid, input user_rready
    );
endinterface

// File: rtl/aib_axi_lite_follower.sv
// rtl/aib_axi_lite_follower.sv - follower AIB-to-AXI-Lite bridge: RX decode, request FIFOs, AXI replay, B/R/credit TX
module aib_axi_lite_follower #(
    parameter int ADDRWIDTH  = 32,
    parameter int DATAWIDTH  = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_online,
    input  logic        tx_online,
    input  logic [79:0] rx_phy,
    output logic [79:0] tx_phy,
    aib_axi_lite_follower_if.master axi,
    output logic        overflow_err,
    output logic        protocol_err
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_REQ, R_DATA} r_state_t;

    w_state_t w_state;
    r_state_t r_state;

    // Channel index order 0 = W, 1 = AW, 2 = AR matches the {ar, aw, w} credit field.
    logic [2:0]  req, push, pop, empty, full, credit_bits;
    logic [35:0] head [3];
    logic [CW-1:0] credit [3];
    logic        rx_acc;
    logic [2:0]  rx_type;
    logic        b_full, r_full, b_take, r_take;
    logic [1:0]  b_resp, r_resp;
    logic [DATAWIDTH-1:0] r_data;
    logic [79:0] tx_next;
    logic        unused_bits;

    assign rx_acc  = rx_online & rx_phy[79];
    assign rx_type = rx_phy[78:76];
    assign req     = {rx_type == 3'b011, rx_type == 3'b001, rx_type == 3'b010} & {3{rx_acc}};
    assign push    = req & (~full | pop);
    assign unused_bits = ^{rx_phy[75:36], head[1][35], head[2][35]};

    genvar c;
    for (c = 0; c < 3; c++) begin : g_fifo
        logic [35:0] mem [FIFO_DEPTH];
        logic [PW:0] wr_ptr, rd_ptr;

        assign empty[c] = (wr_ptr == rd_ptr);
        assign full[c]  = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);
        assign head[c]  = mem[rd_ptr[PW-1:0]];

        always_ff @(posedge clk) begin
            if (push[c]) mem[wr_ptr[PW-1:0]] <= rx_phy[35:0];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push[c]) wr_ptr <= wr_ptr + (PW+1)'(1);
                if (pop[c])  rd_ptr <= rd_ptr + (PW+1)'(1);
            end
        end
    end

    assign pop[0] = (w_state == W_REQ) && axi.user_wvalid && axi.user_wready;
    assign pop[1] = (w_state == W_REQ) && axi.user_awvalid && axi.user_awready;
    assign pop[2] = (r_state == R_REQ) && axi.user_arvalid && axi.user_arready;

    assign axi.user_bready = (w_state == W_RESP) && !b_full;
    assign axi.user_rready = (r_state == R_DATA) && !r_full;
    assign b_take = axi.user_bvalid && axi.user_bready;
    assign r_take = axi.user_rvalid && axi.user_rready;

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state          <= W_IDLE;
            axi.user_awvalid <= 1'b0;
            axi.user_wvalid  <= 1'b0;
            axi.user_awaddr  <= '0;
            axi.user_awprot  <= '0;
            axi.user_wdata   <= '0;
            axi.user_wstrb   <= '0;
        end else begin
            case (w_state)
                W_IDLE: if (!empty[1] && !empty[0]) begin
                    axi.user_awvalid <= 1'b1;
                    axi.user_wvalid  <= 1'b1;
                    axi.user_awaddr  <= head[1][ADDRWIDTH-1:0];
                    axi.user_awprot  <= head[1][34:32];
                    axi.user_wdata   <= head[0][DATAWIDTH-1:0];
                    axi.user_wstrb   <= head[0][DATAWIDTH +: 4];
                    w_state          <= W_REQ;
                end
                W_REQ: begin
                    if (pop[1]) axi.user_awvalid <= 1'b0;
                    if (pop[0]) axi.user_wvalid  <= 1'b0;
                    if ((!axi.user_awvalid || axi.user_awready) && (!axi.user_wvalid || axi.user_wready))
                        w_state <= W_RESP;
                end
                W_RESP: if (b_take) w_state <= W_IDLE;
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= R_IDLE;
            axi.user_arvalid <= 1'b0;
            axi.user_araddr  <= '0;
            axi.user_arprot  <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (!empty[2]) begin
                    axi.user_arvalid <= 1'b1;
                    axi.user_araddr  <= head[2][ADDRWIDTH-1:0];
                    axi.user_arprot  <= head[2][34:32];
                    r_state          <= R_REQ;
                end
                R_REQ: if (pop[2]) begin
                    axi.user_arvalid <= 1'b0;
                    r_state          <= R_DATA;
                end
                R_DATA: if (r_take) r_state <= R_IDLE;
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Credits only leave on a transmitted word; any nonzero counter forces one out.
    for (c = 0; c < 3; c++) begin : g_cbit
        assign credit_bits[c] = tx_online && (credit[c] != '0);
    end

    always_comb begin
        tx_next = '0;
        if (tx_online) begin
            if (b_full) begin
                tx_next[78:76] = 3'b100;
                tx_next[1:0]   = b_resp;
            end else if (r_full) begin
                tx_next[78:76] = 3'b101;
                tx_next[31:0]  = r_data;
                tx_next[33:32] = r_resp;
            end else begin
                tx_next[78:76] = 3'b110;
            end
            tx_next[79]    = b_full || r_full || (|credit_bits);
            tx_next[75:73] = credit_bits;
            if (!tx_next[79]) tx_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_phy       <= '0;
            b_full       <= 1'b0;
            r_full       <= 1'b0;
            b_resp       <= '0;
            r_resp       <= '0;
            r_data       <= '0;
            overflow_err <= 1'b0;
            protocol_err <= 1'b0;
            for (int i = 0; i < 3; i++) credit[i] <= '0;
        end else begin
            tx_phy <= tx_next;
            if (b_take) begin
                b_full <= 1'b1;
                b_resp <= axi.user_bresp;
            end else if (tx_online && b_full) begin
                b_full <= 1'b0;
            end
            if (r_take) begin
                r_full <= 1'b1;
                r_resp <= axi.user_rresp;
                r_data <= axi.user_rdata;
            end else if (tx_online && r_full && !b_full) begin
                r_full <= 1'b0;
            end
            for (int i = 0; i < 3; i++) begin
                case ({pop[i], credit_bits[i]})
                    2'b10:   credit[i] <= credit[i] + CW'(1);
                    2'b01:   credit[i] <= credit[i] - CW'(1);
                    default: credit[i] <= credit[i];
                endcase
            end
            if (|(req & ~push)) overflow_err <= 1'b1;
            if (rx_acc && !(|req)) protocol_err <= 1'b1;
        end
    end
endmodule
